// File: rtl/snap_trig_ctrl_if.sv
// Snapshot BRAM write port: one registered write per accepted sample.
interface snap_trig_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic          bram_we;

    modport master (output bram_addr, output bram_data, output bram_we);
    modport slave  (input  bram_addr, input  bram_data, input  bram_we);
endinterface

// File: rtl/snap_trig_ctrl.sv
// Snapshot capture controller: arms from software, triggers on an external edge or
// immediately, then writes a programmable-length burst of samples into a BRAM.
module snap_trig_ctrl #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic [31:0]          ctrl,
    input  logic [DW-1:0]        din,
    input  logic                 din_valid,
    input  logic                 ext_trig,
    snap_trig_ctrl_if.master     wr,
    output logic [31:0]          status
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t        state, state_nx;
    logic          arm_q, ext_q;
    logic [AW:0]   count, count_nx;
    logic [AW-1:0] len_q, len_nx;
    logic [AW-1:0] addr_q, addr_nx;
    logic [DW-1:0] data_q, data_nx;
    logic          we_q, we_nx;
    logic [31:0]   status_nx;

    logic          arm, trig_sel, gate_en;
    logic [AW-1:0] len_m1;
    logic          accept, arm_rise, ext_rise, trig;
    logic          unused_ctrl_bits;

    assign arm      = ctrl[0];
    assign trig_sel = ctrl[1];
    assign gate_en  = ctrl[2];
    assign len_m1   = ctrl[AW+15:16];
    assign unused_ctrl_bits = ^{ctrl[31:AW+16], ctrl[15:3]};

    assign accept   = gate_en ? din_valid : 1'b1;
    assign arm_rise = arm & ~arm_q;
    assign ext_rise = ext_trig & ~ext_q;
    assign trig     = trig_sel | ext_rise;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_nx = state;
        count_nx = count;
        len_nx   = len_q;
        addr_nx  = addr_q;
        data_nx  = data_q;
        we_nx    = 1'b0;

        case (state)
            IDLE: begin
                if (arm_rise) begin
                    state_nx = ARMED;
                    count_nx = '0;
                end
            end
            ARMED: begin
                // Abort takes priority over a trigger arriving in the same cycle.
                if (!arm) begin
                    state_nx = IDLE;
                end else if (trig) begin
                    len_nx = len_m1;
                    if (accept) begin
                        we_nx    = 1'b1;
                        addr_nx  = '0;
                        data_nx  = din;
                        count_nx = (AW+1)'(1);
                        state_nx = (len_m1 == '0) ? DONE : CAPTURE;
                    end else begin
                        count_nx = '0;
                        state_nx = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (!arm) begin
                    state_nx = IDLE;
                end else if (accept) begin
                    we_nx    = 1'b1;
                    addr_nx  = count[AW-1:0];
                    data_nx  = din;
                    count_nx = count + (AW+1)'(1);
                    if (count == {1'b0, len_q}) state_nx = DONE;
                end
            end
            DONE: begin
                if (arm_rise) begin
                    state_nx = ARMED;
                    count_nx = '0;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Status is registered from next-state values so it changes on the same edge as the FSM.
        status_nx              = '0;
        status_nx[0]           = (state_nx == DONE);
        status_nx[1]           = (state_nx == ARMED);
        status_nx[2]           = (state_nx == CAPTURE);
        status_nx[AW+15:16]    = count_nx[AW-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state  <= IDLE;
            arm_q  <= 1'b0;
            ext_q  <= 1'b0;
            count  <= '0;
            len_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            status <= '0;
        end else begin
            state  <= state_nx;
            arm_q  <= arm;
            ext_q  <= ext_trig;
            count  <= count_nx;
            len_q  <= len_nx;
            addr_q <= addr_nx;
            data_q <= data_nx;
            we_q   <= we_nx;
            status <= status_nx;
        end
    end

    assign wr.bram_addr = addr_q;
    assign wr.bram_data = data_q;
    assign wr.bram_we   = we_q;
endmodule

// File: tb/tb_snap_trig_ctrl.sv
// Directed bench for snap_trig_ctrl: expected BRAM writes are queued as samples are
// driven and popped by a monitor whenever the DUT asserts bram_we.
module tb_snap_trig_ctrl;
    localparam int DW = 32;
    localparam int AW = 10;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          user_clk = 1'b0;
    logic          user_rst = 1'b0;
    logic [31:0]   ctrl = '0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          ext_trig = 1'b0;
    logic [31:0]   status;

    int  n_cmp  = 0;
    int  n_mis  = 0;
    int  n_push = 0;
    int  n_wr   = 0;
    wr_t exp_q[$];

    snap_trig_ctrl_if #(.DW(DW), .AW(AW)) wr ();

    snap_trig_ctrl #(.DW(DW), .AW(AW)) dut (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .ctrl      (ctrl),
        .din       (din),
        .din_valid (din_valid),
        .ext_trig  (ext_trig),
        .wr        (wr.master),
        .status    (status)
    );

    always #5 user_clk = ~user_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_ctrl(input bit arm, input bit tsel, input bit gate, input int len_m1);
        logic [31:0] c;
        c = '0;
        c[0] = arm;
        c[1] = tsel;
        c[2] = gate;
        c[AW+15:16] = len_m1[AW-1:0];
        c[31] = 1'b1;
        c[7]  = 1'b1;
        return c;
    endfunction

    function automatic logic [31:0] stat(input bit done, input bit armed, input bit capt, input int cnt);
        logic [31:0] s;
        s = '0;
        s[0] = done;
        s[1] = armed;
        s[2] = capt;
        s[AW+15:16] = cnt[AW-1:0];
        return s;
    endfunction

    task automatic tick();
        @(posedge user_clk);
        #1;
        din = din + 1;
    endtask

    // The sample on din at the coming edge is expected at address a, visible right after it.
    task automatic cap(input int a);
        wr_t e;
        e.addr = a[AW-1:0];
        e.data = din;
        exp_q.push_back(e);
        n_push++;
        tick();
        check("cap_we", wr.bram_we, 1);
    endtask

    always @(negedge user_clk) begin
        if (wr.bram_we === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("spurious_write_qlen", exp_q.size(), 1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", wr.bram_addr, e.addr);
                check("wr_data", wr.bram_data, e.data);
            end
        end
    end

    initial begin
        // Reset state
        #2 user_rst = 1'b1;
        #1;
        check("rst_we", wr.bram_we, 0);
        check("rst_addr", wr.bram_addr, 0);
        check("rst_data", wr.bram_data, 0);
        check("rst_status", status, 0);
        @(posedge user_clk); @(posedge user_clk); #1;
        user_rst = 1'b0;
        tick();

        // Software trigger, len 8, data from 0x100
        ctrl = mk_ctrl(0, 1, 0, 7);
        tick();
        ctrl = mk_ctrl(1, 1, 0, 7);
        din  = 32'h0FF;
        tick();
        check("sw_armed", status, stat(0, 1, 0, 0));
        for (int i = 0; i < 8; i++) cap(i);
        check("sw_done", status, stat(1, 0, 0, 8));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sw_after_we", wr.bram_we, 0);
        end

        // Done held while arm drops; ext level high before arming gives no trigger
        ctrl = mk_ctrl(0, 0, 0, 3);
        ext_trig = 1'b1;
        tick();
        check("done_held", status, stat(1, 0, 0, 8));
        ctrl = mk_ctrl(1, 0, 0, 3);
        tick();
        check("ext_armed", status, stat(0, 1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ext_high_no_we", wr.bram_we, 0);
        end
        ext_trig = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            check("ext_wait_no_we", wr.bram_we, 0);
        end
        check("ext_still_armed", status, stat(0, 1, 0, 0));
        ext_trig = 1'b1;
        cap(0);
        ext_trig = 1'b0;
        for (int i = 1; i < 4; i++) cap(i);
        check("ext_done", status, stat(1, 0, 0, 4));

        // Trigger and disarm in the same ARMED cycle: abort wins
        ctrl = mk_ctrl(0, 0, 0, 3);
        tick();
        ctrl = mk_ctrl(1, 0, 0, 3);
        tick();
        ctrl = mk_ctrl(0, 1, 0, 3);
        tick();
        check("trig_abort_we", wr.bram_we, 0);
        check("trig_abort_status", status, stat(0, 0, 0, 0));

        // Gated capture, din_valid 1010...
        ctrl = mk_ctrl(1, 1, 1, 3);
        tick();
        for (int i = 0; i < 7; i++) begin
            din_valid = (i % 2 == 0);
            if (din_valid) begin
                cap(i / 2);
            end else begin
                tick();
                check("gate_idle_we", wr.bram_we, 0);
            end
        end
        check("gate_done", status, stat(1, 0, 0, 4));
        din_valid = 1'b1;
        tick();
        check("gate_after_we", wr.bram_we, 0);
        din_valid = 1'b0;

        // len_m1 = 0, accepted on the trigger cycle
        ctrl = mk_ctrl(0, 1, 0, 0);
        tick();
        ctrl = mk_ctrl(1, 1, 0, 0);
        tick();
        cap(0);
        check("len0_done", status, stat(1, 0, 0, 1));

        // len_m1 = 0, trigger cycle not accepted
        ctrl = mk_ctrl(0, 1, 1, 0);
        tick();
        ctrl = mk_ctrl(1, 1, 1, 0);
        tick();
        tick();
        check("len0_gap_we", wr.bram_we, 0);
        check("len0_gap_capt", status, stat(0, 0, 1, 0));
        din_valid = 1'b1;
        cap(0);
        check("len0_gated_done", status, stat(1, 0, 0, 1));
        din_valid = 1'b0;

        // Abort after 5 of 16 writes, then re-arm with len_m1 changed mid-capture
        ctrl = mk_ctrl(0, 1, 0, 15);
        tick();
        ctrl = mk_ctrl(1, 1, 0, 15);
        tick();
        for (int i = 0; i < 5; i++) cap(i);
        ctrl = mk_ctrl(0, 1, 0, 15);
        tick();
        check("abort_we", wr.bram_we, 0);
        check("abort_status", status, stat(0, 0, 0, 5));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_idle_we", wr.bram_we, 0);
        end
        ctrl = mk_ctrl(1, 1, 0, 15);
        tick();
        check("rearm_status", status, stat(0, 1, 0, 0));
        for (int i = 0; i < 16; i++) begin
            cap(i);
            if (i == 3) ctrl = mk_ctrl(1, 1, 0, 2);
            if (i == 9) ctrl = mk_ctrl(1, 1, 0, 100);
        end
        check("lenchg_done", status, stat(1, 0, 0, 16));

        // Full depth
        ctrl = mk_ctrl(0, 1, 0, 1023);
        tick();
        ctrl = mk_ctrl(1, 1, 0, 1023);
        tick();
        for (int i = 0; i < 1024; i++) cap(i);
        check("full_done_wrap", status, stat(1, 0, 0, 1024));
        tick();
        check("full_after_we", wr.bram_we, 0);

        // Asynchronous reset mid-capture
        ctrl = mk_ctrl(0, 1, 0, 15);
        tick();
        ctrl = mk_ctrl(1, 1, 0, 15);
        tick();
        for (int i = 0; i < 3; i++) cap(i);
        @(negedge user_clk);
        #1;
        user_rst = 1'b1;
        ctrl = mk_ctrl(0, 1, 0, 15);
        #1;
        check("arst_we", wr.bram_we, 0);
        check("arst_addr", wr.bram_addr, 0);
        check("arst_data", wr.bram_data, 0);
        check("arst_status", status, 0);
        tick();
        user_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_idle", status, 0);
        end
        ctrl = mk_ctrl(1, 1, 0, 0);
        tick();
        check("post_rst_armed", status, stat(0, 1, 0, 0));
        cap(0);
        check("post_rst_done", status, stat(1, 0, 0, 1));

        tick();
        tick();
        check("queue_empty", exp_q.size(), 0);
        check("write_total", n_wr, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
